toggle_event_decoder: RTL and testbench



---
 rtl/toggle_event_decoder.sv | 129 ++++++++++++
 tb/tb_toggle_event_decoder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_event_decoder.sv
// toggle_event_decoder: recovers events from a toggle-encoded line.
// Each level change on tog_in (after synchronisation) becomes one event.
// Events are buffered in a saturating pending counter on a valid/ready
// interface, with a wrapping total count and a sticky overflow flag.
module toggle_event_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int PEND_W      = 4,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              tog_in,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [PEND_W-1:0] pending,
    output logic [CNT_W-1:0]  evt_count,
    output logic              overflow,
    input  logic              clr_ovf
);

    // Prime counter must be able to count to SYNC_STAGES (2 bits by default).
    localparam int PRIME_W = (SYNC_STAGES + 2 > 4) ? $clog2(SYNC_STAGES + 2) : 2;

    localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(SYNC_STAGES);
    localparam logic [PRIME_W-1:0] PRIME_ONE  = PRIME_W'(1);
    localparam logic [PEND_W-1:0]  PEND_ONE   = PEND_W'(1);
    localparam logic [PEND_W-1:0]  PEND_MAX   = {PEND_W{1'b1}};
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                 state;
    logic [PRIME_W-1:0]     prime_cnt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   s_out;
    logic                   prev;
    logic                   det;
    logic                   pop;

    assign s_out     = sync[SYNC_STAGES-1];
    // Edge detection is suppressed while priming so a high line at reset
    // release is absorbed into prev instead of looking like a toggle.
    assign det       = (s_out ^ prev) && (state == RUN);
    assign evt_valid = (pending != '0);
    assign pop       = evt_valid && evt_ready;

    // Synchroniser chain bringing tog_in into the clk domain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], tog_in};
        end
    end

    // Previous synchronised level, used for change detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev <= 1'b0;
        end else begin
            prev <= s_out;
        end
    end

    // Startup FSM: wait SYNC_STAGES+1 cycles for the chain and prev to settle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= PRIME;
            prime_cnt <= '0;
        end else begin
            case (state)
                PRIME: begin
                    if (prime_cnt == PRIME_LAST) begin
                        state <= RUN;
                    end else begin
                        prime_cnt <= prime_cnt + PRIME_ONE;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state <= PRIME;
                end
            endcase
        end
    end

    // Pending counter: saturating buffer of undelivered events.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending <= '0;
        end else begin
            if (det && !pop) begin
                if (pending != PEND_MAX) begin
                    pending <= pending + PEND_ONE;
                end
            end else if (pop && !det) begin
                pending <= pending - PEND_ONE;
            end
        end
    end

    // Total event counter; counts dropped events too and wraps.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            evt_count <= '0;
        end else if (det) begin
            evt_count <= evt_count + CNT_ONE;
        end
    end

    // Sticky overflow: a drop sets it, clr_ovf clears it, set has priority.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow <= 1'b0;
        end else begin
            if (det && !pop && (pending == PEND_MAX)) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Directed self-checking bench for toggle_event_decoder (default parameters).
module tb_toggle_event_decoder;

    logic       clk;
    logic       rstn;
    logic       tog_in;
    logic       evt_valid;
    logic       evt_ready;
    logic [3:0] pending;
    logic [7:0] evt_count;
    logic       overflow;
    logic       clr_ovf;

    int tests;
    int fails;

    toggle_event_decoder #(
        .SYNC_STAGES(2),
        .PEND_W(4),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .tog_in(tog_in),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .pending(pending),
        .evt_count(evt_count),
        .overflow(overflow),
        .clr_ovf(clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        evt_ready = 1'b0;
        clr_ovf = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        repeat (4) tick();
    endtask

    // Flip the toggle line, then let n clocks pass.
    task automatic toggle(input int n);
        tog_in = ~tog_in;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        tog_in = 1'b1;
        rstn = 1'b0;
        evt_ready = 1'b0;
        clr_ovf = 1'b0;
        tick();
        tick();
        tests++;
        if ({evt_valid, pending, evt_count, overflow} !== 14'd0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%0d p=%0d c=%0d o=%0d, expected all 0",
                     evt_valid, pending, evt_count, overflow);
        end
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            tests++;
            if (evt_valid !== 1'b0 || pending !== 4'd0 || evt_count !== 8'd0) begin
                fails++;
                $display("FAIL prime_high_cycle%0d: got v=%0d p=%0d c=%0d, expected 0 0 0",
                         i, evt_valid, pending, evt_count);
            end
        end
    endtask

    task automatic test_single_event();
        do_reset();
        evt_ready = 1'b0;
        tog_in = ~tog_in;
        tick();
        tick();
        tests++;
        if (pending !== 4'd0) begin
            fails++;
            $display("FAIL latency_early: pending got %0d, expected 0", pending);
        end
        tick();
        tests++;
        if (evt_valid !== 1'b1 || pending !== 4'd1 || evt_count !== 8'd1) begin
            fails++;
            $display("FAIL single_event: got v=%0d p=%0d c=%0d, expected 1 1 1",
                     evt_valid, pending, evt_count);
        end
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        tests++;
        if (evt_valid !== 1'b0 || pending !== 4'd0 || evt_count !== 8'd1) begin
            fails++;
            $display("FAIL single_pop: got v=%0d p=%0d c=%0d, expected 0 0 1",
                     evt_valid, pending, evt_count);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        evt_ready = 1'b0;
        for (int i = 0; i < 15; i++) toggle(4);
        tests++;
        if (pending !== 4'd15 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL full_no_ovf: got p=%0d o=%0d, expected 15 0", pending, overflow);
        end
        for (int i = 0; i < 5; i++) toggle(4);
        tests++;
        if (pending !== 4'd15 || overflow !== 1'b1 || evt_count !== 8'd20) begin
            fails++;
            $display("FAIL saturate: got p=%0d o=%0d c=%0d, expected 15 1 20",
                     pending, overflow, evt_count);
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        tests++;
        if (overflow !== 1'b0 || pending !== 4'd15) begin
            fails++;
            $display("FAIL clr_ovf: got o=%0d p=%0d, expected 0 15", overflow, pending);
        end
        // Drop and clear land on the same edge: the drop must win.
        tog_in = ~tog_in;
        tick();
        tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        tests++;
        if (overflow !== 1'b1 || evt_count !== 8'd21) begin
            fails++;
            $display("FAIL set_beats_clear: got o=%0d c=%0d, expected 1 21", overflow, evt_count);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) toggle(4);
        tests++;
        if (pending !== 4'd5 || evt_count !== 8'd5) begin
            fails++;
            $display("FAIL preload5: got p=%0d c=%0d, expected 5 5", pending, evt_count);
        end
        tog_in = ~tog_in;
        tick();
        tick();
        evt_ready = 1'b1;
        tick();
        tests++;
        if (pending !== 4'd5 || evt_count !== 8'd6) begin
            fails++;
            $display("FAIL det_and_pop: got p=%0d c=%0d, expected 5 6", pending, evt_count);
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
            tests++;
            if (pending !== 4'(5 - i)) begin
                fails++;
                $display("FAIL drain_step%0d: pending got %0d, expected %0d", i, pending, 5 - i);
            end
        end
        tick();
        tests++;
        if (pending !== 4'd0 || evt_valid !== 1'b0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL no_underflow: got p=%0d v=%0d o=%0d, expected 0 0 0",
                     pending, evt_valid, overflow);
        end
        evt_ready = 1'b0;
    endtask

    task automatic test_wrap();
        int max_pend;
        do_reset();
        evt_ready = 1'b1;
        max_pend = 0;
        for (int i = 0; i < 256; i++) begin
            tog_in = ~tog_in;
            for (int j = 0; j < 3; j++) begin
                tick();
                if (int'(pending) > max_pend) max_pend = int'(pending);
            end
            if (i == 254) begin
                tests++;
                if (evt_count !== 8'd255) begin
                    fails++;
                    $display("FAIL count_255: got %0d, expected 255", evt_count);
                end
            end
        end
        tick();
        tests++;
        if (evt_count !== 8'd0 || overflow !== 1'b0 || pending !== 4'd0) begin
            fails++;
            $display("FAIL count_wrap: got c=%0d o=%0d p=%0d, expected 0 0 0",
                     evt_count, overflow, pending);
        end
        tests++;
        if (max_pend > 1) begin
            fails++;
            $display("FAIL wrap_max_pending: got %0d, expected at most 1", max_pend);
        end
        evt_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        evt_ready = 1'b0;
        for (int i = 0; i < 7; i++) toggle(4);
        tests++;
        if (pending !== 4'd7) begin
            fails++;
            $display("FAIL preload7: pending got %0d, expected 7", pending);
        end
        #2;
        rstn = 1'b0;
        #1;
        tests++;
        if ({evt_valid, pending, evt_count, overflow} !== 14'd0) begin
            fails++;
            $display("FAIL async_clear: got v=%0d p=%0d c=%0d o=%0d, expected all 0",
                     evt_valid, pending, evt_count, overflow);
        end
        tog_in = 1'b1;
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests++;
            if (evt_valid !== 1'b0 || evt_count !== 8'd0) begin
                fails++;
                $display("FAIL reprime_cycle%0d: got v=%0d c=%0d, expected 0 0",
                         i, evt_valid, evt_count);
            end
        end
        toggle(4);
        tests++;
        if (evt_count !== 8'd1 || pending !== 4'd1) begin
            fails++;
            $display("FAIL after_reprime: got c=%0d p=%0d, expected 1 1", evt_count, pending);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rstn = 1'b0;
        tog_in = 1'b0;
        evt_ready = 1'b0;
        clr_ovf = 1'b0;
        test_reset();
        test_single_event();
        test_overflow();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
